// File: rtl/if_stage.sv
// Instruction-fetch stage: pre-IF nextpc/SRAM request plus the IF register with a
// one-entry buffer that holds the returned instruction across decode stalls.
module if_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ID_allowin,
    input  logic [32:0] br_bus,
    output logic        IF_ID_valid,
    output logic [63:0] IF_ID_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h1BFF_FFFC;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

    logic            preif_valid_q, preif_valid_d;
    logic            if_valid_q,    if_valid_d;
    logic [XLEN-1:0] if_pc_q,       if_pc_d;
    logic [XLEN-1:0] inst_buf_q,    inst_buf_d;
    logic            inst_buf_valid_q, inst_buf_valid_d;

    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] nextpc;
    logic            if_ready_go;
    logic            if_allowin;
    logic            fetch_req;
    logic [XLEN-1:0] if_inst;

    // Redirect decode, nextpc and handshake; reset masks the request and valid.
    always_comb begin
        br_taken    = br_bus[32];
        br_target   = br_bus[XLEN-1:0];
        nextpc      = br_taken ? br_target : XLEN'(if_pc_q + PC_STEP);
        if_ready_go = 1'b1;
        if_allowin  = ~if_valid_q | (if_ready_go & ID_allowin) | br_taken;
        fetch_req   = preif_valid_q & if_allowin & ~reset;
        if_inst     = inst_buf_valid_q ? inst_buf_q : inst_sram_rdata;
    end

    // Next-state for the IF register and the stall buffer.
    always_comb begin
        preif_valid_d    = 1'b1;
        if_valid_d       = if_valid_q;
        if_pc_d          = if_pc_q;
        inst_buf_d       = inst_buf_q;
        inst_buf_valid_d = inst_buf_valid_q;

        if (fetch_req) begin
            if_pc_d    = nextpc;
            if_valid_d = 1'b1;
        end else if (if_allowin && !preif_valid_q) begin
            if_valid_d = 1'b0;
        end

        // rdata is only valid in the first stall cycle, so capture it exactly then
        if (if_allowin) begin
            inst_buf_valid_d = 1'b0;
        end else if (if_valid_q && !ID_allowin && !br_taken && !inst_buf_valid_q) begin
            inst_buf_d       = inst_sram_rdata;
            inst_buf_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            preif_valid_q    <= 1'b0;
            if_valid_q       <= 1'b0;
            if_pc_q          <= RESET_PC;
            inst_buf_q       <= '0;
            inst_buf_valid_q <= 1'b0;
        end else begin
            preif_valid_q    <= preif_valid_d;
            if_valid_q       <= if_valid_d;
            if_pc_q          <= if_pc_d;
            inst_buf_q       <= inst_buf_d;
            inst_buf_valid_q <= inst_buf_valid_d;
        end
    end

    assign IF_ID_valid     = if_valid_q & if_ready_go & ~br_taken & ~reset;
    assign IF_ID_bus       = {if_inst, if_pc_q};
    assign inst_sram_en    = fetch_req;
    assign inst_sram_we    = 4'b0000;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = '0;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: IF_stage

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: ID_allowin  input  1  decode stage can accept an instruction this cycle.
REQ-004 SHALL have port: br_bus  input  33  {br_taken[32], br_target[31:0]}; redirect request from decode, single-cycle pulse.
REQ-005 SHALL have port: IF_ID_valid  output  1  IF_ID_bus holds a valid, non-cancelled instruction.
REQ-006 SHALL have port: IF_ID_bus  output  64  {IF_inst[63:32], IF_pc[31:0]}.
REQ-007 SHALL have port: inst_sram_en  output  1  instruction SRAM read request.
REQ-008 SHALL have port: inst_sram_we  output  4  byte write enables; constant 4'b0.
REQ-009 SHALL have port: inst_sram_addr  output  32  fetch address (nextpc).
REQ-010 SHALL have port: inst_sram_wdata  output  32  constant 32'b0.
REQ-011 SHALL have port: inst_sram_rdata  input  32  read data, valid exactly one cycle after an enabled request; undefined otherwise.

Function
REQ-012 SHALL implement two pipeline points: pre-IF (nextpc generation, SRAM request) and IF (registered IF_pc, IF_valid, returned instruction).
REQ-013 SHALL hold a registered preIF_valid: 0 while reset, 1 from the first cycle after reset deasserts.
REQ-014 SHALL compute nextpc = br_taken ? br_target : IF_pc + 4 (32-bit, wraps modulo 2^32).
REQ-015 SHALL define IF_ready_go = 1 and IF_allowin = ~IF_valid | (IF_ready_go & ID_allowin) | br_taken.
REQ-016 SHALL drive inst_sram_en = preIF_valid & IF_allowin and inst_sram_addr = nextpc (combinational).
REQ-017 SHALL, on a cycle with inst_sram_en = 1, load IF_pc <= nextpc and IF_valid <= 1; with IF_allowin = 1 and preIF_valid = 0, load IF_valid <= 0.
REQ-018 SHALL hold IF_pc and IF_valid when IF_allowin = 0.
REQ-019 SHALL drive IF_ID_valid = IF_valid & IF_ready_go & ~br_taken; a wrong-path instruction in IF during a redirect is never presented as valid.
REQ-020 SHALL contain a 32-bit instruction buffer inst_buf and flag inst_buf_valid.
REQ-021 SHALL set inst_buf <= inst_sram_rdata and inst_buf_valid <= 1 when IF_valid & ~ID_allowin & ~br_taken & ~inst_buf_valid (first stall cycle, the only cycle rdata is valid).
REQ-022 SHALL clear inst_buf_valid on any cycle with IF_allowin = 1 (new fetch or redirect), taking priority over the set in REQ-021.
REQ-023 SHALL select IF_inst = inst_buf_valid ? inst_buf : inst_sram_rdata.
REQ-024 SHALL keep IF_ID_bus stable across an ID stall of any length (same IF_pc, same IF_inst).
REQ-025 SHALL accept a redirect regardless of ID_allowin: a br_taken cycle always issues a fetch of br_target and discards the IF instruction and buffer.
REQ-026 SHALL allow back-to-back redirects; each issues a fetch to its own br_target.
REQ-027 SHALL treat the instruction SRAM as always ready (no wait states); the fetch latency is 1 cycle from request to IF.

Reset
REQ-028 SHALL, while reset = 1: IF_pc <= 32'h1BFFFFFC, IF_valid <= 0, preIF_valid <= 0, inst_buf_valid <= 0, inst_buf <= 0.
REQ-029 SHALL, during reset, drive IF_ID_valid = 0 and inst_sram_en = 0; inst_sram_we and inst_sram_wdata remain 0 at all times.
REQ-030 SHALL make the first request after reset to address 32'h1C000000, in the first cycle after reset deasserts.
REQ-031 SHALL abandon any in-flight fetch or buffered instruction on reset asserted mid-operation, with no output glitch in the cycle after.

Verification
REQ-032 SHALL pass: reset 3 cycles, ID_allowin = 1 -> inst_sram_en rises the first cycle after reset; addresses 0x1C000000, 0x1C000004, 0x1C000008...; IF_ID_valid high from the next cycle with matching pc.
REQ-033 SHALL pass: ID_allowin low 4 cycles with IF_pc = 0x1C000008, rdata = 0x02800421 in the first stall cycle and then garbage -> inst_sram_en = 0 throughout, IF_ID_bus = {0x02800421, 0x1C000008} held; on release, next address 0x1C00000C.
REQ-034 SHALL pass: br_bus = {1, 0x1C000100} while IF_pc = 0x1C000010 -> IF_ID_valid = 0 that cycle, inst_sram_addr = 0x1C000100, next IF_pc = 0x1C000100, next address 0x1C000104.
REQ-035 SHALL pass: redirect to 0x1C000200 during an ID stall with the buffer full -> fetch issued, buffer cleared, IF_ID_bus pc = 0x1C000200 next cycle with the new rdata.
REQ-036 SHALL pass: reset asserted during a stall with the buffer full -> the next cycle shows IF_ID_valid = 0 and inst_buf_valid = 0, and the restart fetches 0x1C000000.
REQ-037 SHALL pass: IF_pc = 0xFFFFFFFC, no branch -> nextpc = 0x00000000.
